// File: rtl/board_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : board_input_conditioner
// Function : board clock divider/strobe, input synchronise+debounce with edge
//            pulses, and a stretched SoC reset from a raw reset button.
// Revision : 1.0
// ============================================================================
module board_input_conditioner #(
  parameter int                    DIVIDE_BY         = 2,
  parameter int                    NUM_INPUTS        = 4,
  parameter int                    DEBOUNCE_CYCLES   = 1000000,
  parameter int                    RESET_HOLD_CYCLES = 16,
  parameter logic [NUM_INPUTS-1:0] INPUT_RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_INPUTS-1:0] raw_inputs,
  input  logic                  reset_button,
  output logic                  clock_divided,
  output logic                  clock_enable,
  output logic [NUM_INPUTS-1:0] debounced,
  output logic [NUM_INPUTS-1:0] rise_pulse,
  output logic [NUM_INPUTS-1:0] fall_pulse,
  output logic                  system_reset_n
);

  localparam int c_HALF   = DIVIDE_BY / 2;
  localparam int c_DIV_W  = (c_HALF > 1) ? $clog2(c_HALF) : 1;
  localparam int c_DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int c_HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam int c_NCH    = NUM_INPUTS + 1;

  localparam logic [c_DIV_W-1:0]  c_DIV_TERM = c_DIV_W'(c_HALF - 1);
  localparam logic [c_DEB_W-1:0]  c_DEB_MAX  = c_DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(RESET_HOLD_CYCLES - 1);
  // Channel NUM_INPUTS is the reset button, which always resets low.
  localparam logic [c_NCH-1:0]    c_SYNC_RST = {1'b0, INPUT_RESET_VALUE};

  logic [c_DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic               div_clk_q, div_clk_d;
  logic               div_en_q;

  always_comb begin
    div_cnt_d = div_cnt_q + c_DIV_W'(1);
    div_clk_d = div_clk_q;
    if (div_cnt_q == c_DIV_TERM) begin
      div_cnt_d = '0;
      div_clk_d = ~div_clk_q;
    end
  end

  // Strobe is registered so it lines up with the cycle whose end raises the divided clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      div_clk_q <= 1'b0;
      div_en_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      div_clk_q <= div_clk_d;
      div_en_q  <= (div_cnt_d == c_DIV_TERM) && !div_clk_d;
    end
  end

  logic [c_NCH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= c_SYNC_RST;
      sync2_q <= c_SYNC_RST;
    end else begin
      sync1_q <= {reset_button, raw_inputs};
      sync2_q <= sync1_q;
    end
  end

  logic [c_NCH-1:0] deb_w;
  logic [c_NCH-1:0] accept_w;

  for (genvar i = 0; i < c_NCH; i++) begin : g_chan
    logic [c_DEB_W-1:0] cnt_q;
    logic               deb_q;

    assign accept_w[i] = (sync2_q[i] != deb_q) && (cnt_q == c_DEB_MAX);
    assign deb_w[i]    = deb_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
        deb_q <= c_SYNC_RST[i];
      end else if (sync2_q[i] == deb_q) begin
        cnt_q <= '0;
      end else if (accept_w[i]) begin
        cnt_q <= '0;
        deb_q <= sync2_q[i];
      end else begin
        cnt_q <= cnt_q + c_DEB_W'(1);
      end
    end
  end

  logic [NUM_INPUTS-1:0] rise_q, fall_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= accept_w[NUM_INPUTS-1:0] &  sync2_q[NUM_INPUTS-1:0];
      fall_q <= accept_w[NUM_INPUTS-1:0] & ~sync2_q[NUM_INPUTS-1:0];
    end
  end

  typedef enum logic [0:0] {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } rst_state_t;

  rst_state_t          rst_state_q;
  logic [c_HOLD_W-1:0] hold_cnt_q;
  logic                sys_rst_n_q;
  logic                btn_w;

  assign btn_w = deb_w[NUM_INPUTS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_state_q <= ST_HOLD;
      hold_cnt_q  <= '0;
      sys_rst_n_q <= 1'b0;
    end else begin
      case (rst_state_q)
        ST_HOLD: begin
          if (btn_w) begin
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == c_HOLD_MAX) begin
            hold_cnt_q  <= '0;
            rst_state_q <= ST_RUN;
            sys_rst_n_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + c_HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (btn_w) begin
            hold_cnt_q  <= '0;
            rst_state_q <= ST_HOLD;
            sys_rst_n_q <= 1'b0;
          end
        end
        default: begin
          hold_cnt_q  <= '0;
          rst_state_q <= ST_HOLD;
          sys_rst_n_q <= 1'b0;
        end
      endcase
    end
  end

  assign clock_divided  = div_clk_q;
  assign clock_enable   = div_en_q;
  assign debounced      = deb_w[NUM_INPUTS-1:0];
  assign rise_pulse     = rise_q;
  assign fall_pulse     = fall_q;
  assign system_reset_n = sys_rst_n_q;

endmodule
`default_nettype wire

// File: tb/tb_board_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_input_conditioner
// Function : directed self-checking bench for board_input_conditioner.
// Revision : 1.0
// ============================================================================
module tb_board_input_conditioner;

  localparam int NI = 2;

  logic          clock        = 1'b0;
  logic          reset_n      = 1'b0;
  logic [NI-1:0] raw_inputs   = '0;
  logic          reset_button = 1'b0;
  logic          clock_divided;
  logic          clock_enable;
  logic [NI-1:0] debounced;
  logic [NI-1:0] rise_pulse;
  logic [NI-1:0] fall_pulse;
  logic          system_reset_n;

  int checks = 0;
  int errors = 0;

  board_input_conditioner #(
    .DIVIDE_BY         (4),
    .NUM_INPUTS        (NI),
    .DEBOUNCE_CYCLES   (4),
    .RESET_HOLD_CYCLES (3),
    .INPUT_RESET_VALUE (2'b00)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .raw_inputs     (raw_inputs),
    .reset_button   (reset_button),
    .clock_divided  (clock_divided),
    .clock_enable   (clock_enable),
    .debounced      (debounced),
    .rise_pulse     (rise_pulse),
    .fall_pulse     (fall_pulse),
    .system_reset_n (system_reset_n)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_cd;
  logic [7:0] exp_en;

  initial begin
    exp_cd = 8'b0110_0110;
    exp_en = 8'b0001_0001;

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_cd",   32'(clock_divided),  32'd0);
    check("rst_en",   32'(clock_enable),   32'd0);
    check("rst_deb",  32'(debounced),      32'd0);
    check("rst_rise", 32'(rise_pulse),     32'd0);
    check("rst_fall", 32'(fall_pulse),     32'd0);
    check("rst_sys",  32'(system_reset_n), 32'd0);

    // Release: divider pattern and reset stretch (rises on 3rd edge)
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      check("div_cd",   32'(clock_divided),  32'(exp_cd[k-1]));
      check("div_en",   32'(clock_enable),   32'(exp_en[k-1]));
      check("por_sys",  32'(system_reset_n), 32'(k >= 3));
    end

    // Channel 0 rise, 6-cycle latency
    raw_inputs[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      check("r0_deb",  32'(debounced[0]),  32'(k >= 6));
      check("r0_rise", 32'(rise_pulse[0]), 32'(k == 6));
      check("r0_ch1",  32'(debounced[1]),  32'd0);
    end

    // Channel 1: 3-cycle glitch rejected
    raw_inputs[1] = 1'b1;
    repeat (3) @(negedge clock);
    raw_inputs[1] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      check("g1_deb",  32'(debounced[1]),  32'd0);
      check("g1_rise", 32'(rise_pulse[1]), 32'd0);
    end

    // Channel 1: held high accepted
    raw_inputs[1] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      check("h1_deb",  32'(debounced[1]),  32'(k >= 6));
      check("h1_rise", 32'(rise_pulse[1]), 32'(k == 6));
    end

    // Reset button: 10-cycle press from RUN
    reset_button = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      check("btn_press", 32'(system_reset_n), 32'(k < 7));
    end
    reset_button = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      check("btn_rel", 32'(system_reset_n), 32'(k >= 9));
    end
    check("btn_deb", 32'(debounced), 32'd3);

    // Channel 0 fall
    raw_inputs[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      check("f0_deb",  32'(debounced[0]),  32'(k < 6));
      check("f0_fall", 32'(fall_pulse[0]), 32'(k == 6));
      check("f0_rise", 32'(rise_pulse[0]), 32'd0);
    end

    // reset_n mid-debounce (channel 0 counter at 2)
    raw_inputs[0] = 1'b1;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_deb",  32'(debounced),      32'd0);
    check("mid_rise", 32'(rise_pulse),     32'd0);
    check("mid_fall", 32'(fall_pulse),     32'd0);
    check("mid_sys",  32'(system_reset_n), 32'd0);
    check("mid_cd",   32'(clock_divided),  32'd0);
    check("mid_en",   32'(clock_enable),   32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      check("post_deb",  32'(debounced),      (k >= 6) ? 32'd3 : 32'd0);
      check("post_rise", 32'(rise_pulse),     (k == 6) ? 32'd3 : 32'd0);
      check("post_sys",  32'(system_reset_n), 32'(k >= 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
